count_display_mux: RTL
======================

COUNT_DISPLAY_MUX -- requirements
Module: count_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000, clock cycles each digit is driven before advancing (legal range 1..65535).
REQ-002 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port COUNT  input  10  binary value from the upstream ripple counter, asynchronous to CLK.
REQ-005 SHALL have port SEG  output  7  segment drive, active-high, bit0=a .. bit6=g.
REQ-006 SHALL have port DIG  output  4  one-hot digit enable, active-high, DIG[0]=units .. DIG[3]=thousands.
REQ-007 SHALL have port BUSY  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-008 SHALL pass each COUNT bit through a 2-flop synchronizer; the synchronized word is "stable" when equal on two consecutive CLK edges.
REQ-009 SHALL run FSM IDLE -> CONVERT -> LOAD -> IDLE; IDLE leaves only when the stable word differs from the last converted word, or on the first stable word after reset.
REQ-010 SHALL capture the stable word on the IDLE->CONVERT edge (E0), perform one double-dabble shift per edge E1..E10, and write the 4 BCD digits to the display register at edge E11 (LOAD->IDLE).
REQ-011 SHALL drive BUSY high from after E0 until after E11, low otherwise.
REQ-012 SHALL ignore COUNT changes during CONVERT/LOAD; a newer stable value is taken on the next IDLE cycle.
REQ-013 SHALL hold the display register unchanged between LOADs (no partially converted digits ever shown).
REQ-014 SHALL produce thousands digit 0 or 1 only (COUNT max 1023); hundreds/tens/units 0..9.
REQ-015 SHALL run a prescaler 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-016 SHALL, with REFRESH_DIV=1, advance the digit index every CLK edge.
REQ-017 SHALL drive DIG = one-hot(index) and SEG = decode(display[index]) combinationally from registered state.
REQ-018 SHALL decode 0..9 to (g..a) 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
REQ-019 SHALL let a LOAD and a prescaler wrap on the same edge both take effect; the newly indexed digit shows the new value.

Reset
REQ-020 SHALL, on RST high, immediately clear synchronizers, display register (all 0), prescaler (0), index (0), FSM to IDLE, and mark last-converted word invalid.
REQ-021 SHALL output DIG=4'b0001, SEG=0x3F, BUSY=0 while RST is high and until the first index advance.
REQ-022 SHALL abort any conversion in progress on RST; no LOAD occurs for the aborted value.

Configuration
REQ-023 SHALL, with LEADING_ZERO_BLANK_EN defined, force SEG=0 for digit 3, 2, 1 when that digit and all higher digits are 0; digit 0 is never blanked; DIG is unaffected.
REQ-024 SHALL, without LEADING_ZERO_BLANK_EN, display all four digits including leading zeros.

Structure
REQ-025 SHALL place the 7-segment decode constants, digit count (4), and FSM state encoding in shared package count_display_pkg.
REQ-026 SHALL implement the shift-and-add-3 converter as sub-module bin2bcd_seq (start, 10-bit in, 4x4-bit out, done).

Verification
REQ-027 SHALL cover: RST pulse then COUNT=0 -> DIG=0001, SEG=0x3F; BUSY pulses once for 11 cycles after stable detect.
REQ-028 SHALL cover: COUNT=1023, REFRESH_DIV=4 -> DIG cycles 0001,0010,0100,1000 every 4 cycles with SEG 0x4F,0x5B,0x3F,0x06.
REQ-029 SHALL cover: COUNT 100->101 held stable -> display changes exactly at E11 after capture; old digits shown until then.
REQ-030 SHALL cover: COUNT toggled every cycle for 20 cycles -> no conversion starts; after settling at 512 one conversion yields digits 0,5,1,2.
REQ-031 SHALL cover: RST asserted at E5 of a conversion of 999 -> BUSY=0 immediately, display stays 0000, no LOAD.
REQ-032 SHALL cover: LEADING_ZERO_BLANK_EN defined, COUNT=7 -> SEG=0 on digits 3..1, 0x07 on digit 0; COUNT=0 -> digit 0 shows 0x3F.

Source files
------------

// File: rtl/count_display_pkg.sv
// ---------------------------------------------------------------------------
// count_display_pkg
// Shared definitions for the count display multiplexer and its
// binary-to-BCD converter: digit count, word widths, the conversion
// FSM state encoding and the 7-segment decode table.
// No ports. Segment bits are ordered g..a (bit0 = a, bit6 = g).
// ---------------------------------------------------------------------------
package count_display_pkg;

   localparam int NUM_DIGITS  = 4;
   localparam int COUNT_WIDTH = 10;
   localparam int BCD_WIDTH   = 4 * NUM_DIGITS;
   localparam int SHIFT_STEPS = COUNT_WIDTH;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_LOAD    = 2'd2
   } conv_state_t;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Codes above 9 cannot come out of the converter; they decode dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add-3 (double dabble) converter: one shift per clock.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset, aborts a running conversion
//   start      loads bin_value on this edge and begins converting
//   bin_value  10-bit binary input
//   units, tens, hundreds, thousands  BCD digits, final after the 10th shift
//   done       high in the cycle whose closing edge performs the final shift
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import count_display_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] bin_value,
   output logic [3:0]             units,
   output logic [3:0]             tens,
   output logic [3:0]             hundreds,
   output logic [3:0]             thousands,
   output logic                   done
);

   logic [COUNT_WIDTH-1:0]           bin_reg;
   logic [BCD_WIDTH-1:0]             bcd_reg;
   logic [BCD_WIDTH-1:0]             bcd_adj;
   logic [BCD_WIDTH+COUNT_WIDTH-1:0] shifted;
   logic [3:0]                       step;
   logic                             active;

   // Add-3 correction on every BCD nibble of 5 or more, then shift the
   // whole BCD:binary word left by one so the next binary bit enters.
   always_comb begin
      bcd_adj = bcd_reg;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_reg[i*4 +: 4] >= 4'd5)
            bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
      end
      shifted = {bcd_adj, bin_reg} << 1;
   end

   // Conversion register: start loads a fresh word, then ten shifts run.
   // The result stays put afterwards until the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg <= '0;
         bcd_reg <= '0;
         step    <= '0;
         active  <= 1'b0;
      end else if (start) begin
         bin_reg <= bin_value;
         bcd_reg <= '0;
         step    <= '0;
         active  <= 1'b1;
      end else if (active) begin
         {bcd_reg, bin_reg} <= shifted;
         step               <= step + 4'd1;
         if (step == 4'(SHIFT_STEPS - 1))
            active <= 1'b0;
      end
   end

   // Flagging the last shift one cycle early lets the caller leave its
   // convert state on the same edge that completes the digits.
   assign done      = active && (step == 4'(SHIFT_STEPS - 1));
   assign units     = bcd_reg[3:0];
   assign tens      = bcd_reg[7:4];
   assign hundreds  = bcd_reg[11:8];
   assign thousands = bcd_reg[15:12];

endmodule

// File: rtl/count_display_mux.sv
// ---------------------------------------------------------------------------
// count_display_mux
// Synchronizes a 10-bit count from an asynchronous ripple counter, converts
// each new stable value to four BCD digits and time-multiplexes them onto a
// common 7-segment display.
// Parameter:
//   REFRESH_DIV  clock cycles each digit is driven before advancing (1..65535)
// Ports:
//   CLK    rising-edge clock
//   RST    asynchronous active-high reset
//   COUNT  10-bit binary count, asynchronous to CLK
//   SEG    active-high segments, bit0 = a .. bit6 = g
//   DIG    one-hot digit enable, DIG[0] = units .. DIG[3] = thousands
//   BUSY   high while a conversion is in progress
// Build option:
//   LEADING_ZERO_BLANK_EN  blanks leading zero digits (units never blanked)
// ---------------------------------------------------------------------------
module count_display_mux
   import count_display_pkg::*;
#(
   parameter int REFRESH_DIV = 1000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [COUNT_WIDTH-1:0] COUNT,
   output logic [6:0]             SEG,
   output logic [3:0]             DIG,
   output logic                   BUSY
);

   localparam logic [15:0] PRESCALE_LAST = 16'(REFRESH_DIV - 1);

   logic [COUNT_WIDTH-1:0] sync_a;
   logic [COUNT_WIDTH-1:0] sync_b;
   logic [COUNT_WIDTH-1:0] sync_prev;
   logic [1:0]             sync_fill;
   logic                   stable;
   logic [COUNT_WIDTH-1:0] last_word;
   logic                   last_valid;
   conv_state_t            state;
   conv_state_t            next_state;
   logic                   start;
   logic                   load;
   logic                   conv_done;
   logic [3:0]             conv_units;
   logic [3:0]             conv_tens;
   logic [3:0]             conv_hundreds;
   logic [3:0]             conv_thousands;
   logic [BCD_WIDTH-1:0]   display;
   logic [15:0]            prescale;
   logic [1:0]             index;
   logic [3:0]             shown_digit;

   // Two-flop synchronizer plus one more register to spot a word that held
   // still across two edges. sync_fill keeps the all-zero reset contents of
   // the pipeline from being mistaken for a real stable sample.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_a    <= '0;
         sync_b    <= '0;
         sync_prev <= '0;
         sync_fill <= '0;
      end else begin
         sync_a    <= COUNT;
         sync_b    <= sync_a;
         sync_prev <= sync_b;
         if (sync_fill != 2'd3)
            sync_fill <= sync_fill + 2'd1;
      end
   end

   assign stable = (sync_fill == 2'd3) && (sync_b == sync_prev);

   // Remember the word handed to the converter so an unchanged count does
   // not trigger another conversion.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_word  <= '0;
         last_valid <= 1'b0;
      end else if (start) begin
         last_word  <= sync_b;
         last_valid <= 1'b1;
      end
   end

   // Conversion FSM state register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   // Next state: only IDLE looks at the input, so count changes during a
   // conversion are picked up on the following IDLE cycle.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:
            if (stable && (!last_valid || (sync_b != last_word)))
               next_state = ST_CONVERT;
         ST_CONVERT:
            if (conv_done)
               next_state = ST_LOAD;
         ST_LOAD:
            next_state = ST_IDLE;
         default:
            next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: start pulses on the capture edge, load on the edge that
   // copies the finished digits into the display register.
   always_comb begin
      start = 1'b0;
      load  = 1'b0;
      BUSY  = 1'b0;
      case (state)
         ST_IDLE:    start = (next_state == ST_CONVERT);
         ST_CONVERT: BUSY  = 1'b1;
         ST_LOAD: begin
            BUSY = 1'b1;
            load = 1'b1;
         end
         default: ;
      endcase
   end

   bin2bcd_seq converter (
      .clk       (CLK),
      .rst       (RST),
      .start     (start),
      .bin_value (sync_b),
      .units     (conv_units),
      .tens      (conv_tens),
      .hundreds  (conv_hundreds),
      .thousands (conv_thousands),
      .done      (conv_done)
   );

   // Display register only changes on LOAD, so the multiplexer never sees
   // a half-converted value.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         display <= '0;
      else if (load)
         display <= {conv_thousands, conv_hundreds, conv_tens, conv_units};
   end

   // Refresh prescaler and digit index; with REFRESH_DIV = 1 the terminal
   // count is 0 and the index steps on every edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prescale <= '0;
         index    <= '0;
      end else if (prescale == PRESCALE_LAST) begin
         prescale <= '0;
         index    <= index + 2'd1;
      end else begin
         prescale <= prescale + 16'd1;
      end
   end

   // Digit select and segment decode straight from registered state.
   // Blanking looks at the selected digit and everything above it at once.
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic [BCD_WIDTH-1:0] upper;
`endif
      DIG         = 4'b0001 << index;
      shown_digit = display[{index, 2'b00} +: 4];
      SEG         = seg_decode(shown_digit);
`ifdef LEADING_ZERO_BLANK_EN
      upper = display >> {index, 2'b00};
      if ((index != 2'd0) && (upper == '0))
         SEG = SEG_BLANK;
`endif
   end

endmodule
